// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: generic valid/ready pipeline stage with a two-entry skid buffer.
// The main entry drives every out_* port. The skid entry holds one extra beat,
// so in_ready is a plain register bit with no combinational path from out_ready.
// The stall/flush/cpu_en semantics and the hazard flags used by the forwarding
// unit are the same as in the fixed-field ID/EX register this stage replaces.
// Optional feature: define PIPE_SKID_STAT_EN to add the stall_cycles
// backpressure counter and its output port.
module pipe_skid_reg #(
  parameter int DATA_WIDTH     = 160,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int STAT_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_en,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_gpr_we,
  input  logic                      in_is_load,
  input  logic [GPR_ADDR_WIDTH-1:0] in_dst_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_gpr_we,
  output logic                      out_is_load,
  output logic [GPR_ADDR_WIDTH-1:0] out_dst_addr,
  output logic                      load_in_stage,
`ifdef PIPE_SKID_STAT_EN
  output logic [STAT_WIDTH-1:0]     stall_cycles,
`endif
  output logic                      alu2gpr_in_stage
);

  // The state encoding is chosen so that bit 0 is "main entry valid" and bit 1
  // is "skid entry valid". out_valid and in_ready are then single flop bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_e;

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     main_data_q, main_data_d;
  logic                      main_gpr_we_q, main_gpr_we_d;
  logic                      main_is_load_q, main_is_load_d;
  logic [GPR_ADDR_WIDTH-1:0] main_dst_q, main_dst_d;
  logic [DATA_WIDTH-1:0]     skid_data_q, skid_data_d;
  logic                      skid_gpr_we_q, skid_gpr_we_d;
  logic                      skid_is_load_q, skid_is_load_d;
  logic [GPR_ADDR_WIDTH-1:0] skid_dst_q, skid_dst_d;

  logic in_fire;
  logic out_fire;

  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];

  assign in_fire  = cpu_en & in_valid & in_ready;
  assign out_fire = cpu_en & out_valid & out_ready;

  assign out_data     = main_data_q;
  assign out_gpr_we   = main_gpr_we_q;
  assign out_is_load  = main_is_load_q;
  assign out_dst_addr = main_dst_q;

  // Hazard flags look only at the head beat; a beat in the skid entry has not
  // reached this stage from the forwarding unit's point of view.
  assign load_in_stage    = out_valid & main_gpr_we_q & main_is_load_q;
  assign alu2gpr_in_stage = out_valid & main_gpr_we_q & ~main_is_load_q;

  // Next-state and next-entry logic. flush wins over any handshake transfer.
  always_comb begin
    state_d        = state_q;
    main_data_d    = main_data_q;
    main_gpr_we_d  = main_gpr_we_q;
    main_is_load_d = main_is_load_q;
    main_dst_d     = main_dst_q;
    skid_data_d    = skid_data_q;
    skid_gpr_we_d  = skid_gpr_we_q;
    skid_is_load_d = skid_is_load_q;
    skid_dst_d     = skid_dst_q;

    if (flush) begin
      state_d        = ST_EMPTY;
      main_data_d    = '0;
      main_gpr_we_d  = 1'b0;
      main_is_load_d = 1'b0;
      main_dst_d     = '0;
      skid_data_d    = '0;
      skid_gpr_we_d  = 1'b0;
      skid_is_load_d = 1'b0;
      skid_dst_d     = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d        = ST_FULL;
            main_data_d    = in_data;
            main_gpr_we_d  = in_gpr_we;
            main_is_load_d = in_is_load;
            main_dst_d     = in_dst_addr;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_data_d    = in_data;
            main_gpr_we_d  = in_gpr_we;
            main_is_load_d = in_is_load;
            main_dst_d     = in_dst_addr;
          end else if (in_fire) begin
            state_d        = ST_SKID;
            skid_data_d    = in_data;
            skid_gpr_we_d  = in_gpr_we;
            skid_is_load_d = in_is_load;
            skid_dst_d     = in_dst_addr;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_d        = ST_FULL;
            main_data_d    = skid_data_q;
            main_gpr_we_d  = skid_gpr_we_q;
            main_is_load_d = skid_is_load_q;
            main_dst_d     = skid_dst_q;
            skid_data_d    = '0;
            skid_gpr_we_d  = 1'b0;
            skid_is_load_d = 1'b0;
            skid_dst_d     = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STAT_EN
  logic [STAT_WIDTH-1:0] stall_q, stall_d;

  // Backpressure counter: counts enabled cycles where the head beat is
  // blocked. It saturates instead of wrapping, and only rst clears it.
  always_comb begin
    stall_d = stall_q;
    if (cpu_en && out_valid && !out_ready && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

  // Stage registers. Reset clears everything. flush is applied through the
  // _d logic so that it also takes effect when cpu_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_EMPTY;
      main_data_q    <= '0;
      main_gpr_we_q  <= 1'b0;
      main_is_load_q <= 1'b0;
      main_dst_q     <= '0;
      skid_data_q    <= '0;
      skid_gpr_we_q  <= 1'b0;
      skid_is_load_q <= 1'b0;
      skid_dst_q     <= '0;
    end else if (cpu_en || flush) begin
      state_q        <= state_d;
      main_data_q    <= main_data_d;
      main_gpr_we_q  <= main_gpr_we_d;
      main_is_load_q <= main_is_load_d;
      main_dst_q     <= main_dst_d;
      skid_data_q    <= skid_data_d;
      skid_gpr_we_q  <= skid_gpr_we_d;
      skid_is_load_q <= skid_is_load_d;
      skid_dst_q     <= skid_dst_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random stimulus for pipe_skid_reg, checked
// against a queue model of the stage. The model holds up to two beats, is
// cleared by reset and by flush, pops on out_fire and pushes on in_fire.
// The optional stall counter is checked when PIPE_SKID_STAT_EN is defined.
module tb_pipe_skid_reg;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef PIPE_SKID_STAT_EN
  localparam int SW = 4;
`else
  localparam int SW = 32;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          we;
    logic          ld;
    logic [AW-1:0] dst;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, cpu_en, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic          in_gpr_we, in_is_load, out_gpr_we, out_is_load;
  logic [AW-1:0] in_dst_addr, out_dst_addr;
  logic          load_in_stage, alu2gpr_in_stage;
`ifdef PIPE_SKID_STAT_EN
  logic [SW-1:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .DATA_WIDTH(DW),
    .GPR_ADDR_WIDTH(AW),
    .STAT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_en(cpu_en),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_gpr_we(in_gpr_we),
    .in_is_load(in_is_load),
    .in_dst_addr(in_dst_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_gpr_we(out_gpr_we),
    .out_is_load(out_is_load),
    .out_dst_addr(out_dst_addr),
    .load_in_stage(load_in_stage),
`ifdef PIPE_SKID_STAT_EN
    .stall_cycles(stall_cycles),
`endif
    .alu2gpr_in_stage(alu2gpr_in_stage)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t q[$];
  bit    known  = 1'b0;   // model valid once a reset has been applied
  bit    zeroed = 1'b0;   // stored fields are known to be zero
  longint stall_m = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model state, apply one clock with the
  // given inputs, then advance the model with the stage's queue semantics.
  task automatic cycle(input logic r, input logic f, input logic en,
                       input logic iv, input logic ordy, input beat_t b);
    bit do_in, do_out;
    rst = r; flush = f; cpu_en = en; in_valid = iv; out_ready = ordy;
    in_data = b.data; in_gpr_we = b.we; in_is_load = b.ld; in_dst_addr = b.dst;
    #1;
    if (known) begin
      check_eq("out_valid", out_valid, q.size() > 0);
      check_eq("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        check_eq("out_data", out_data, q[0].data);
        check_eq("out_gpr_we", out_gpr_we, q[0].we);
        check_eq("out_is_load", out_is_load, q[0].ld);
        check_eq("out_dst", out_dst_addr, q[0].dst);
        check_eq("load_flag", load_in_stage, q[0].we & q[0].ld);
        check_eq("alu_flag", alu2gpr_in_stage, q[0].we & ~q[0].ld);
      end else begin
        check_eq("load_flag_e", load_in_stage, 0);
        check_eq("alu_flag_e", alu2gpr_in_stage, 0);
        if (zeroed) begin
          check_eq("zero_data", out_data, 0);
          check_eq("zero_ctl", {out_gpr_we, out_is_load, out_dst_addr}, 0);
        end
      end
`ifdef PIPE_SKID_STAT_EN
      check_eq("stall_cycles", stall_cycles, stall_m);
`endif
    end
    do_in  = en && iv && (q.size() < 2);
    do_out = en && (q.size() > 0) && ordy;
    if (!r && en && q.size() > 0 && !ordy && stall_m < (2**SW - 1)) stall_m++;
    @(posedge clk);
    if (r) begin
      q.delete(); known = 1'b1; zeroed = 1'b1; stall_m = 0;
    end else if (f) begin
      q.delete(); zeroed = 1'b1;
    end else begin
      if (do_out) void'(q.pop_front());
      if (do_in) begin q.push_back(b); zeroed = 1'b0; end
    end
    #1;
  endtask

  function automatic beat_t mk(input int v, input logic we, input logic ld, input int dst);
    beat_t b;
    b.data = v; b.we = we; b.ld = ld; b.dst = dst[AW-1:0];
    return b;
  endfunction

  initial begin
    beat_t z;
    z = mk(0, 0, 0, 0);
    rst = 1; flush = 0; cpu_en = 1; in_valid = 0; out_ready = 0;
    in_data = 0; in_gpr_we = 0; in_is_load = 0; in_dst_addr = 0;
    @(posedge clk); #1;

    // Reset, then a single load beat.
    cycle(1, 0, 1, 0, 1, z);
    cycle(1, 0, 1, 0, 1, z);
    cycle(0, 0, 1, 1, 1, mk('hA5, 1, 1, 7));
    check_eq("a5_load_flag", load_in_stage, 1);
    check_eq("a5_data", out_data, 'hA5);
    cycle(0, 0, 1, 0, 1, z);

    // Streaming with continuous out_ready.
    for (int i = 1; i <= 8; i++) cycle(0, 0, 1, 1, 1, mk(i, 1, 0, i));
    cycle(0, 0, 1, 0, 1, z);
    cycle(0, 0, 1, 0, 1, z);

    // Skid fill, then drain in order.
    cycle(0, 0, 1, 1, 1, mk(1, 1, 0, 1));
    cycle(0, 0, 1, 1, 0, mk(2, 1, 0, 2));
    check_eq("skid_in_ready", in_ready, 0);
    cycle(0, 0, 1, 0, 1, z);
    cycle(0, 0, 1, 0, 1, z);
    cycle(0, 0, 1, 0, 1, z);

    // Flush from SKID with a concurrent beat that must be dropped.
    cycle(0, 0, 1, 1, 0, mk(3, 1, 1, 3));
    cycle(0, 0, 1, 1, 0, mk(4, 0, 0, 4));
    cycle(0, 1, 1, 1, 0, mk(5, 1, 1, 5));
    check_eq("flush_out_data", out_data, 0);
    cycle(0, 0, 1, 0, 1, z);
    cycle(0, 0, 1, 0, 1, z);

    // cpu_en low on a FULL stage, then resume.
    cycle(0, 0, 1, 1, 0, mk(9, 1, 0, 9));
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1, mk(10 + i, 1, 1, i));
    cycle(0, 0, 1, 1, 1, mk(20, 0, 1, 20));
    cycle(0, 0, 1, 0, 1, z);
    cycle(0, 0, 1, 0, 1, z);

    // Long stall: saturates the counter when it is present.
    cycle(0, 0, 1, 1, 0, mk(30, 1, 0, 30));
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 0, 0, z);
    cycle(0, 1, 1, 0, 0, z);
    cycle(0, 0, 1, 0, 0, z);
    cycle(1, 0, 1, 0, 0, z);
    cycle(0, 0, 1, 0, 0, z);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 9) < 6),
            mk($urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
